bank_htu_plru_array: RTL
========================

Name: bank_htu_plru_array

Overview:
- Multi-set, parametrised tree-PLRU replacement engine for the bank hit/tag unit (HTU).
- Holds one (WAYS-1)-bit PLRU tree per set in a flop array.
- Updates the addressed set's tree on a one-hot way access.
- Answers victim queries with a 1-cycle registered result. Victim selection honours invalid-way priority and a per-query lock mask.
- Provides a sequential init sweep that clears all sets, for flush and reconfiguration.

Parameters:
- WAYS, 8, associativity; power of two, >=2.
- SETS, 16, number of sets; >=2.
- SET_W, $clog2(SETS), set index width.
- NODES, WAYS-1, tree bits per set (derived; not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- upd_vld_i  in  1  access update strobe.
- upd_set_i  in  SET_W  set being accessed.
- upd_way_i  in  WAYS  accessed way, one-hot. If multi-hot, the lowest set bit wins. Zero means no update.
- qry_vld_i  in  1  victim query strobe.
- qry_set_i  in  SET_W  set being queried.
- qry_valid_ways_i  in  WAYS  ways holding valid lines.
- qry_lock_ways_i  in  WAYS  ways excluded from replacement.
- victim_vld_o  out  1  query result valid; pulses 1 cycle after an accepted query.
- victim_way_o  out  WAYS  one-hot victim; 0 when victim_none_o=1.
- victim_none_o  out  1  all ways locked, no victim.
- init_i  in  1  start clearing all set trees.
- init_busy_o  out  1  init sweep in progress.

Behaviour:
- Tree encoding:
  - Heap numbering: node 1 is the root; node n has children 2n (lower half) and 2n+1 (upper half). Leaf node L maps to way L-WAYS.
  - Stored bit index is n-1. Bit=1 means the older side is the upper child.
- Update: for each node on the path to accessed way w, the bit is set to point away from w (bit = 1 if w is in the lower child, else 0). Off-path nodes are unchanged. The write takes effect at the clock edge following upd_vld_i.
- Query, evaluated combinationally on the effective state:
  - Effective state is the stored tree, or the post-update tree when upd_vld_i=1 and upd_set_i==qry_set_i in the same cycle (bypass).
  - Let C = ~qry_valid_ways_i & ~qry_lock_ways_i. If C≠0, the victim is the lowest-index set bit of C.
  - Otherwise walk from the root. At each node, take the pointed child unless that subtree is entirely locked, in which case take the other child.
  - If all ways are locked, assert victim_none_o=1 and drive victim_way_o=0.
  - Results are registered. victim_vld_o/victim_way_o/victim_none_o hold for exactly 1 cycle; otherwise they are 0.
- Queries never modify state. Back-to-back queries are allowed every cycle. Update and query may be different sets in the same cycle.
- Init FSM, states IDLE and SWEEP:
  - IDLE→SWEEP when init_i=1.
  - SWEEP clears one set per cycle, starting at set 0, with the counter incrementing. SWEEP→IDLE after set SETS-1 is cleared.
  - init_busy_o=1 for exactly SETS cycles, starting the cycle after init_i.
  - init_i while busy is ignored.
  - While busy, upd_vld_i and qry_vld_i are ignored. No victim_vld_o pulse is produced for a query issued while busy.
- Reset (rst_ni=0 at a clock edge):
  - All trees are cleared to 0 and the FSM goes to IDLE with the counter at 0.
  - All outputs are 0.
  - Reset mid-sweep aborts the sweep.
  - Inputs are ignored during the reset cycle.

Decomposition:
- Package bank_htu_pkg holds the following, all parametrised by WAYS:
  - Default WAYS/SETS localparams.
  - Init FSM state enum.
  - Helper functions: path-node update mask/value for a way; lowest-set-bit one-hot.
- Sub-module bank_htu_plru_victim: combinational tree walk with lock skip and invalid priority over one tree. Instantiated once on the bypassed query tree.

Test Plan:
- Reset, then query set 0 with valid=8'hFF, lock=0 -> victim_way_o=8'h01 next cycle.
- Update set 2 way 0, next cycle query set 2 (valid=FF, lock=0) -> 8'h10. Tree bits 0, 1 and 3 (nodes 1, 2, 4) are 1.
- Updates to set 5 with ways 0,4,2,6,1,5,3 in consecutive cycles, then query -> 8'h80. Query set 6 -> 8'h01 (no cross-set interference).
- After reset: lock=8'h0F -> 8'h10; lock=8'hFF -> victim_none_o=1, way=0; valid=8'hFB, lock=0 -> 8'h04. Then valid=8'hFB, lock=8'h04 -> 8'h01 (tree walk).
- Same-cycle update set 3 way 0 and query set 3 -> 8'h10 (bypass). Update set 3 while querying set 4 -> 8'h01.
- Train set 7 to victim 8'h80, pulse init_i -> init_busy_o high 16 cycles. A query issued during busy gives no victim_vld_o. After busy, query set 7 -> 8'h01. Repeat with rst_ni=0 asserted mid-sweep -> busy drops next cycle, all sets read 8'h01.

Source files
------------

// File: rtl/bank_htu_pkg.sv
// Shared types and helpers for the bank HTU tree-PLRU replacement engine.
// Helpers work on the widest supported tree; callers cast down to their own width.
package bank_htu_pkg;

    localparam int unsigned DEF_WAYS   = 8;
    localparam int unsigned DEF_SETS   = 16;
    localparam int unsigned MAX_WAYS   = 64;
    localparam int unsigned MAX_NODES  = MAX_WAYS - 1;
    localparam int unsigned MAX_LEVELS = 6;

    typedef enum logic {
        INIT_IDLE,
        INIT_SWEEP
    } init_state_e;

    // Isolate the lowest set bit of a vector.
    function automatic logic [MAX_WAYS-1:0] lsb_onehot(input logic [MAX_WAYS-1:0] x);
        return x & (~x + MAX_WAYS'(1));
    endfunction

    // Tree bits on the root-to-leaf path of a way.
    function automatic logic [MAX_NODES-1:0] path_mask(input int unsigned ways,
                                                       input int unsigned way);
        logic [MAX_NODES-1:0] m;
        int unsigned          n;
        m = '0;
        n = ways + way;
        for (int k = 0; k < MAX_LEVELS; k++) begin
            if (n > 1) begin
                m = m | (MAX_NODES'(1) << ((n >> 1) - 1));
                n = n >> 1;
            end
        end
        return m;
    endfunction

    // Values that make every path node point away from the way: 1 when the way is in the lower child.
    function automatic logic [MAX_NODES-1:0] path_value(input int unsigned ways,
                                                        input int unsigned way);
        logic [MAX_NODES-1:0] v;
        int unsigned          n;
        v = '0;
        n = ways + way;
        for (int k = 0; k < MAX_LEVELS; k++) begin
            if (n > 1) begin
                if ((n & 1) == 0) begin
                    v = v | (MAX_NODES'(1) << ((n >> 1) - 1));
                end
                n = n >> 1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/bank_htu_plru_victim.sv
// Combinational victim pick over one PLRU tree: free (invalid, unlocked) ways first,
// otherwise a root-to-leaf walk that steers around fully locked subtrees.
module bank_htu_plru_victim
    import bank_htu_pkg::*;
#(
    parameter int unsigned WAYS = DEF_WAYS
) (
    input  logic [WAYS-2:0] tree,
    input  logic [WAYS-1:0] valid_ways,
    input  logic [WAYS-1:0] lock_ways,
    output logic [WAYS-1:0] victim_c,
    output logic            none_c
);

    logic [WAYS-1:0]   cand;
    logic [WAYS-1:0]   pick;
    logic [WAYS-1:0]   walk;
    logic [2*WAYS-1:1] sub_lock;
    logic [2*WAYS-1:1] cur;
    logic              go_up;

    always_comb begin
        cand     = ~valid_ways & ~lock_ways;
        pick     = WAYS'(lsb_onehot(MAX_WAYS'(cand)));
        sub_lock = '0;
        cur      = '0;
        go_up    = 1'b0;

        // Heap-indexed "whole subtree locked" flags, built leaves-up.
        for (int l = 0; l < WAYS; l++) begin
            sub_lock[WAYS+l] = lock_ways[l];
        end
        for (int n = WAYS - 1; n >= 1; n--) begin
            sub_lock[n] = sub_lock[2*n] & sub_lock[2*n+1];
        end

        // Children always have larger heap indices, so one ascending pass walks the tree.
        cur[1] = 1'b1;
        for (int n = 1; n < WAYS; n++) begin
            if (cur[n]) begin
                go_up = tree[n-1];
                if (go_up ? sub_lock[2*n+1] : sub_lock[2*n]) begin
                    go_up = ~go_up;
                end
                if (go_up) begin
                    cur[2*n+1] = 1'b1;
                end else begin
                    cur[2*n] = 1'b1;
                end
            end
        end
        walk = cur[2*WAYS-1:WAYS];

        none_c   = sub_lock[1];
        victim_c = none_c ? '0 : ((|cand) ? pick : walk);
    end

endmodule

// File: rtl/bank_htu_plru_array.sv
// Per-set tree-PLRU state array with same-cycle update bypass into a registered
// victim query, plus a one-set-per-cycle init sweep.
module bank_htu_plru_array
    import bank_htu_pkg::*;
#(
    parameter int unsigned WAYS  = DEF_WAYS,
    parameter int unsigned SETS  = DEF_SETS,
    parameter int unsigned SET_W = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             upd_vld_i,
    input  logic [SET_W-1:0] upd_set_i,
    input  logic [WAYS-1:0]  upd_way_i,
    input  logic             qry_vld_i,
    input  logic [SET_W-1:0] qry_set_i,
    input  logic [WAYS-1:0]  qry_valid_ways_i,
    input  logic [WAYS-1:0]  qry_lock_ways_i,
    output logic             victim_vld_o,
    output logic [WAYS-1:0]  victim_way_o,
    output logic             victim_none_o,
    input  logic             init_i,
    output logic             init_busy_o
);

    localparam int unsigned NODES = WAYS - 1;

    logic [NODES-1:0] tree_q [SETS];

    init_state_e      state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             clr_en;
    logic             busy;

    int unsigned      upd_idx;
    logic [NODES-1:0] upd_mask;
    logic [NODES-1:0] upd_val;
    logic [NODES-1:0] upd_new;
    logic             upd_en;
    logic             qry_en;
    logic [NODES-1:0] qry_tree;

    logic [WAYS-1:0]  vic_way;
    logic             vic_none;

    assign busy   = (state_q == INIT_SWEEP);
    assign upd_en = upd_vld_i & (|upd_way_i) & ~busy;
    assign qry_en = qry_vld_i & ~busy;

    // Accessed way index (lowest set bit wins) and the resulting tree for that set.
    always_comb begin
        upd_idx = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (upd_way_i[i]) begin
                upd_idx = i;
            end
        end
        upd_mask = NODES'(path_mask(WAYS, upd_idx));
        upd_val  = NODES'(path_value(WAYS, upd_idx));
        upd_new  = (tree_q[upd_set_i] & ~upd_mask) | (upd_val & upd_mask);
        qry_tree = (upd_en && (upd_set_i == qry_set_i)) ? upd_new : tree_q[qry_set_i];
    end

    bank_htu_plru_victim #(
        .WAYS(WAYS)
    ) u_victim (
        .tree       (qry_tree),
        .valid_ways (qry_valid_ways_i),
        .lock_ways  (qry_lock_ways_i),
        .victim_c   (vic_way),
        .none_c     (vic_none)
    );

    // Init sweep next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            INIT_IDLE: begin
                if (init_i) begin
                    state_d = INIT_SWEEP;
                    cnt_d   = '0;
                end
            end
            INIT_SWEEP: begin
                clr_en = 1'b1;
                if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = INIT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            default: begin
                state_d = INIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= INIT_IDLE;
            cnt_q         <= '0;
            init_busy_o   <= 1'b0;
            victim_vld_o  <= 1'b0;
            victim_way_o  <= '0;
            victim_none_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_busy_o   <= (state_d == INIT_SWEEP);
            victim_vld_o  <= qry_en;
            victim_way_o  <= qry_en ? vic_way : '0;
            victim_none_o <= qry_en & vic_none;
        end
    end

    // Updates are blocked while sweeping, so the two writes never collide.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            if (upd_en) begin
                tree_q[upd_set_i] <= upd_new;
            end
            if (clr_en) begin
                tree_q[cnt_q] <= '0;
            end
        end
    end

endmodule
